// File: rtl/btime_pkg.sv
`default_nettype none
// ============================================================================
// Module      : btime_pkg
// Description : Shared types and constants for the Burger Time ROM download
//               and reset sequencer.
// Contents    : load_state_t   - sequencer state encoding
//               BTIME_ROM_SIZE - exact byte count of a valid ROM image
//               BTIME_DN_ADDR_W- width of the core download address
// Revision    : 1.0 - initial release
// ============================================================================
package btime_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    SETTLE = 2'd2,
    RUN    = 2'd3
  } load_state_t;

  localparam int BTIME_ROM_SIZE  = 90112;  // 0x16000
  localparam int BTIME_DN_ADDR_W = 17;

endpackage
`default_nettype wire

// File: rtl/edge_det.sv
`default_nettype none
// ============================================================================
// Module      : edge_det
// Description : Single-register edge detector. Produces one-cycle rise/fall
//               pulses comparing the current level against its registered
//               copy. Also used for the coin/start inputs.
// Ports       : clk   - clock
//               rst_n - synchronous active-low reset (clears the copy to 0)
//               level - input level
//               rise  - level & ~prev
//               fall  - ~level & prev
// Revision    : 1.0 - initial release
// ============================================================================
module edge_det (
  input  logic clk,
  input  logic rst_n,
  input  logic level,
  output logic rise,
  output logic fall
);

  logic prev_q;
  logic prev_d;

  always_comb begin
    prev_d = level;
    rise   = level & ~prev_q;
    fall   = ~level & prev_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prev_q <= 1'b0;
    end else begin
      prev_q <= prev_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/btime_load_seq.sv
`default_nettype none
// ============================================================================
// Module      : btime_load_seq
// Description : Sequences ROM download and core reset for the Burger Time
//               core. Registers and range-filters the ioctl write stream,
//               keeps a mod-256 checksum and saturating byte count, and holds
//               the core in reset until a complete image is loaded, then for
//               HOLD_CYC cycles after load completion or external reset.
// Ports       : clk_sys        - system clock
//               reset_n        - synchronous active-low reset
//               ioctl_download - download active level
//               ioctl_wr       - one-cycle byte write strobe
//               ioctl_addr     - 25-bit byte address
//               ioctl_dout     - byte data
//               ext_reset      - external reset level
//               dn_addr/dn_data/dn_wr - registered write port to the core
//               core_reset     - active-high core reset
//               loaded/overflow/checksum/byte_count - last download status
// Revision    : 1.0 - initial release
// ============================================================================
module btime_load_seq
  import btime_pkg::*;
#(
  parameter int ADDR_W   = BTIME_DN_ADDR_W,
  parameter int ROM_SIZE = BTIME_ROM_SIZE,
  parameter int HOLD_CYC = 16
) (
  input  logic              clk_sys,
  input  logic              reset_n,
  input  logic              ioctl_download,
  input  logic              ioctl_wr,
  input  logic [24:0]       ioctl_addr,
  input  logic [7:0]        ioctl_dout,
  input  logic              ext_reset,
  output logic [ADDR_W-1:0] dn_addr,
  output logic [7:0]        dn_data,
  output logic              dn_wr,
  output logic              core_reset,
  output logic              loaded,
  output logic              overflow,
  output logic [7:0]        checksum,
  output logic [17:0]       byte_count
);

  localparam logic [24:0] ROM_LIMIT = 25'(ROM_SIZE);
  localparam logic [17:0] ROM_COUNT = 18'(ROM_SIZE);
  localparam logic [17:0] COUNT_MAX = '1;
  localparam logic [7:0]  HOLD_LAST = 8'(HOLD_CYC - 1);

  logic dl_rise_raw;
  logic dl_rise;
  logic dl_fall;

  edge_det u_dl_edge (
    .clk   (clk_sys),
    .rst_n (reset_n),
    .level (ioctl_download),
    .rise  (dl_rise_raw),
    .fall  (dl_fall)
  );

  load_state_t       state_q,      state_d;
  logic [7:0]        cnt_q,        cnt_d;
  logic              dl_armed_q,   dl_armed_d;
  logic [ADDR_W-1:0] dn_addr_q,    dn_addr_d;
  logic [7:0]        dn_data_q,    dn_data_d;
  logic              dn_wr_q,      dn_wr_d;
  logic              core_reset_q, core_reset_d;
  logic              loaded_q,     loaded_d;
  logic              overflow_q,   overflow_d;
  logic [7:0]        checksum_q,   checksum_d;
  logic [17:0]       byte_count_q, byte_count_d;

  logic in_range;
  logic wr_accept;
  logic wr_drop;

  always_comb begin
    // The edge register comes out of reset at 0, so a download still active
    // across reset would look like a fresh rise. Only arm rise detection once
    // the download level has been seen low, so the remainder of an
    // interrupted download is ignored.
    dl_armed_d = dl_armed_q | ~ioctl_download;
    dl_rise    = dl_rise_raw & dl_armed_q;

    in_range  = (ioctl_addr < ROM_LIMIT);
    wr_accept = (state_q == LOAD) & ioctl_wr & in_range;
    wr_drop   = (state_q == LOAD) & ioctl_wr & ~in_range;

    state_d      = state_q;
    cnt_d        = cnt_q;
    dn_addr_d    = dn_addr_q;
    dn_data_d    = dn_data_q;
    dn_wr_d      = wr_accept;
    loaded_d     = loaded_q;
    overflow_d   = overflow_q;
    checksum_d   = checksum_q;
    byte_count_d = byte_count_q;

    if (wr_accept) begin
      dn_addr_d  = ioctl_addr[ADDR_W-1:0];
      dn_data_d  = ioctl_dout;
      checksum_d = checksum_q + ioctl_dout;
      if (byte_count_q != COUNT_MAX) begin
        byte_count_d = byte_count_q + 18'd1;
      end
    end
    if (wr_drop) begin
      overflow_d = 1'b1;
    end

    if (dl_rise) begin
      state_d      = LOAD;
      cnt_d        = 8'd0;
      loaded_d     = 1'b0;
      overflow_d   = 1'b0;
      checksum_d   = 8'd0;
      byte_count_d = 18'd0;
    end else if (dl_fall && (state_q == LOAD)) begin
      // Completeness uses the _d values so a write landing in the fall cycle
      // is included.
      if ((byte_count_d == ROM_COUNT) && !overflow_d) begin
        loaded_d = 1'b1;
        state_d  = SETTLE;
        cnt_d    = 8'd0;
      end else begin
        loaded_d = 1'b0;
        state_d  = IDLE;
      end
    end else if (ext_reset) begin
      if ((state_q == SETTLE) || (state_q == RUN)) begin
        state_d = SETTLE;
        cnt_d   = 8'd0;
      end
    end else if (state_q == SETTLE) begin
      if (cnt_q == HOLD_LAST) begin
        state_d = RUN;
        cnt_d   = 8'd0;
      end else begin
        cnt_d = cnt_q + 8'd1;
      end
    end

    // Registered alongside the state so core_reset drops on the RUN edge.
    core_reset_d = (state_d != RUN);
  end

  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      cnt_q        <= 8'd0;
      dl_armed_q   <= 1'b0;
      dn_addr_q    <= '0;
      dn_data_q    <= 8'd0;
      dn_wr_q      <= 1'b0;
      core_reset_q <= 1'b1;
      loaded_q     <= 1'b0;
      overflow_q   <= 1'b0;
      checksum_q   <= 8'd0;
      byte_count_q <= 18'd0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      dl_armed_q   <= dl_armed_d;
      dn_addr_q    <= dn_addr_d;
      dn_data_q    <= dn_data_d;
      dn_wr_q      <= dn_wr_d;
      core_reset_q <= core_reset_d;
      loaded_q     <= loaded_d;
      overflow_q   <= overflow_d;
      checksum_q   <= checksum_d;
      byte_count_q <= byte_count_d;
    end
  end

  assign dn_addr    = dn_addr_q;
  assign dn_data    = dn_data_q;
  assign dn_wr      = dn_wr_q;
  assign core_reset = core_reset_q;
  assign loaded     = loaded_q;
  assign overflow   = overflow_q;
  assign checksum   = checksum_q;
  assign byte_count = byte_count_q;

endmodule
`default_nettype wire

// File: tb/tb_btime_load_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_btime_load_seq
// Description : Directed testbench for btime_load_seq. The ROM image size is
//               scaled down to 256 bytes so each full download stays short;
//               all boundary behaviour is relative to that size.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_btime_load_seq;

  localparam int ADDR_W   = 17;
  localparam int ROM_SIZE = 256;
  localparam int HOLD_CYC = 16;

  logic              clk_sys = 1'b0;
  logic              reset_n;
  logic              ioctl_download;
  logic              ioctl_wr;
  logic [24:0]       ioctl_addr;
  logic [7:0]        ioctl_dout;
  logic              ext_reset;
  logic [ADDR_W-1:0] dn_addr;
  logic [7:0]        dn_data;
  logic              dn_wr;
  logic              core_reset;
  logic              loaded;
  logic              overflow;
  logic [7:0]        checksum;
  logic [17:0]       byte_count;

  int n_cmp = 0;
  int n_bad = 0;

  btime_load_seq #(
    .ADDR_W   (ADDR_W),
    .ROM_SIZE (ROM_SIZE),
    .HOLD_CYC (HOLD_CYC)
  ) dut (
    .clk_sys        (clk_sys),
    .reset_n        (reset_n),
    .ioctl_download (ioctl_download),
    .ioctl_wr       (ioctl_wr),
    .ioctl_addr     (ioctl_addr),
    .ioctl_dout     (ioctl_dout),
    .ext_reset      (ext_reset),
    .dn_addr        (dn_addr),
    .dn_data        (dn_data),
    .dn_wr          (dn_wr),
    .core_reset     (core_reset),
    .loaded         (loaded),
    .overflow       (overflow),
    .checksum       (checksum),
    .byte_count     (byte_count)
  );

  always #5 clk_sys = ~clk_sys;

  // Inputs change 1 time unit after the rising edge; outputs are observed
  // at the same point, i.e. they reflect the edge just taken.
  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  // Drives n back-to-back writes from base; data is 0x01 or the low byte of
  // the index. Returns how many of the following cycles showed dn_wr high.
  task automatic do_writes(input int base, input int n, input bit ones,
                           output int wr_seen);
    wr_seen = 0;
    for (int i = 0; i < n; i++) begin
      ioctl_wr   = 1'b1;
      ioctl_addr = 25'(base + i);
      ioctl_dout = ones ? 8'h01 : 8'(i);
      tick();
      if (dn_wr === 1'b1) wr_seen++;
    end
    ioctl_wr = 1'b0;
  endtask

  // Counts consecutive observed cycles of core_reset high, bounded.
  task automatic count_hold(output int hi);
    hi = 0;
    while ((core_reset === 1'b1) && (hi < 60)) begin
      hi++;
      tick();
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) tick();
    n_cmp++; if (dn_addr !== 17'd0) begin n_bad++; $display("FAIL reset_dn_addr: got %0h want 0", dn_addr); end
    n_cmp++; if (dn_data !== 8'd0) begin n_bad++; $display("FAIL reset_dn_data: got %0h want 0", dn_data); end
    n_cmp++; if (dn_wr !== 1'b0) begin n_bad++; $display("FAIL reset_dn_wr: got %0b want 0", dn_wr); end
    n_cmp++; if (core_reset !== 1'b1) begin n_bad++; $display("FAIL reset_core_reset: got %0b want 1", core_reset); end
    n_cmp++; if (loaded !== 1'b0) begin n_bad++; $display("FAIL reset_loaded: got %0b want 0", loaded); end
    n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL reset_overflow: got %0b want 0", overflow); end
    n_cmp++; if (checksum !== 8'd0) begin n_bad++; $display("FAIL reset_checksum: got %0h want 0", checksum); end
    n_cmp++; if (byte_count !== 18'd0) begin n_bad++; $display("FAIL reset_byte_count: got %0d want 0", byte_count); end
    reset_n = 1'b1;
    repeat (3) tick();
    n_cmp++; if (core_reset !== 1'b1) begin n_bad++; $display("FAIL idle_core_reset: got %0b want 1", core_reset); end
  endtask

  task automatic test_full_load();
    int seen;
    int hi;
    ioctl_download = 1'b1;
    tick();
    ioctl_wr = 1'b1; ioctl_addr = 25'd0; ioctl_dout = 8'h01;
    tick();
    n_cmp++; if (dn_wr !== 1'b1) begin n_bad++; $display("FAIL full_first_dn_wr: got %0b want 1", dn_wr); end
    n_cmp++; if ((dn_addr !== 17'd0) || (dn_data !== 8'h01)) begin n_bad++; $display("FAIL full_first_addr_data: got %0h/%0h want 0/01", dn_addr, dn_data); end
    n_cmp++; if (byte_count !== 18'd1) begin n_bad++; $display("FAIL full_first_count: got %0d want 1", byte_count); end
    do_writes(1, ROM_SIZE - 1, 1'b1, seen);
    n_cmp++; if (seen != ROM_SIZE - 1) begin n_bad++; $display("FAIL full_back_to_back: got %0d strobes want %0d", seen, ROM_SIZE - 1); end
    ioctl_download = 1'b0;
    tick();
    n_cmp++; if (dn_wr !== 1'b0) begin n_bad++; $display("FAIL full_dn_wr_single: got %0b want 0", dn_wr); end
    n_cmp++; if (byte_count !== 18'd256) begin n_bad++; $display("FAIL full_byte_count: got %0d want 256", byte_count); end
    n_cmp++; if (checksum !== 8'h00) begin n_bad++; $display("FAIL full_checksum: got %0h want 00", checksum); end
    n_cmp++; if ((loaded !== 1'b1) || (overflow !== 1'b0)) begin n_bad++; $display("FAIL full_loaded: got loaded=%0b ovf=%0b want 1/0", loaded, overflow); end
    count_hold(hi);
    n_cmp++; if (hi != HOLD_CYC) begin n_bad++; $display("FAIL full_settle_len: got %0d want %0d", hi, HOLD_CYC); end
  endtask

  task automatic test_ext_reset();
    int hi;
    ext_reset = 1'b1;
    tick();
    n_cmp++; if (core_reset !== 1'b1) begin n_bad++; $display("FAIL ext_assert: got %0b want 1", core_reset); end
    repeat (4) tick();
    ext_reset = 1'b0;
    count_hold(hi);
    n_cmp++; if (hi != HOLD_CYC) begin n_bad++; $display("FAIL ext_settle_len: got %0d want %0d", hi, HOLD_CYC); end
  endtask

  task automatic test_short_load();
    int seen;
    int hi;
    ioctl_download = 1'b1;
    tick();
    n_cmp++; if ((core_reset !== 1'b1) || (byte_count !== 18'd0) || (loaded !== 1'b0)) begin n_bad++; $display("FAIL short_entry: got rst=%0b cnt=%0d ld=%0b want 1/0/0", core_reset, byte_count, loaded); end
    do_writes(0, 100, 1'b0, seen);
    n_cmp++; if (seen != 100) begin n_bad++; $display("FAIL short_strobes: got %0d want 100", seen); end
    ioctl_download = 1'b0;
    tick();
    n_cmp++; if ((byte_count !== 18'd100) || (checksum !== 8'h56)) begin n_bad++; $display("FAIL short_count_sum: got %0d/%0h want 100/56", byte_count, checksum); end
    n_cmp++; if ((loaded !== 1'b0) || (overflow !== 1'b0)) begin n_bad++; $display("FAIL short_flags: got ld=%0b ovf=%0b want 0/0", loaded, overflow); end
    count_hold(hi);
    n_cmp++; if (hi != 60) begin n_bad++; $display("FAIL short_hold: got %0d cycles high want 60", hi); end
  endtask

  task automatic test_overflow();
    int seen;
    int hi;
    ioctl_download = 1'b1;
    tick();
    do_writes(0, ROM_SIZE, 1'b1, seen);
    n_cmp++; if (seen != ROM_SIZE) begin n_bad++; $display("FAIL ovf_strobes: got %0d want %0d", seen, ROM_SIZE); end
    ioctl_wr = 1'b1; ioctl_addr = 25'h100; ioctl_dout = 8'hAA;
    tick();
    n_cmp++; if ((dn_wr !== 1'b0) || (dn_addr !== 17'h0FF)) begin n_bad++; $display("FAIL ovf_drop_boundary: got wr=%0b addr=%0h want 0/ff", dn_wr, dn_addr); end
    n_cmp++; if (overflow !== 1'b1) begin n_bad++; $display("FAIL ovf_flag: got %0b want 1", overflow); end
    // Low 17 bits are in range; only the full-width compare rejects it.
    ioctl_addr = 25'h1000005;
    tick();
    n_cmp++; if ((dn_wr !== 1'b0) || (byte_count !== 18'd256)) begin n_bad++; $display("FAIL ovf_drop_high: got wr=%0b cnt=%0d want 0/256", dn_wr, byte_count); end
    ioctl_wr = 1'b0;
    ioctl_download = 1'b0;
    tick();
    n_cmp++; if ((loaded !== 1'b0) || (overflow !== 1'b1) || (checksum !== 8'h00)) begin n_bad++; $display("FAIL ovf_final: got ld=%0b ovf=%0b sum=%0h want 0/1/00", loaded, overflow, checksum); end
    count_hold(hi);
    n_cmp++; if (hi != 60) begin n_bad++; $display("FAIL ovf_hold: got %0d cycles high want 60", hi); end
  endtask

  task automatic test_edge_collision();
    int seen;
    int hi;
    ioctl_download = 1'b1;
    tick();
    do_writes(0, ROM_SIZE - 1, 1'b1, seen);
    ioctl_wr = 1'b1; ioctl_addr = 25'(ROM_SIZE - 1); ioctl_dout = 8'h01;
    ioctl_download = 1'b0;
    tick();
    ioctl_wr = 1'b0;
    n_cmp++; if ((dn_wr !== 1'b1) || (dn_addr !== 17'h0FF)) begin n_bad++; $display("FAIL coll_last_write: got wr=%0b addr=%0h want 1/ff", dn_wr, dn_addr); end
    n_cmp++; if ((loaded !== 1'b1) || (byte_count !== 18'd256)) begin n_bad++; $display("FAIL coll_loaded: got ld=%0b cnt=%0d want 1/256", loaded, byte_count); end
    count_hold(hi);
    n_cmp++; if (hi != HOLD_CYC) begin n_bad++; $display("FAIL coll_settle_len: got %0d want %0d", hi, HOLD_CYC); end
    // Rise outranks ext_reset.
    ioctl_download = 1'b1;
    ext_reset = 1'b1;
    tick();
    ioctl_wr = 1'b1; ioctl_addr = 25'd3; ioctl_dout = 8'h5A;
    tick();
    ioctl_wr = 1'b0;
    n_cmp++; if ((dn_wr !== 1'b1) || (byte_count !== 18'd1) || (checksum !== 8'h5A)) begin n_bad++; $display("FAIL rise_vs_ext: got wr=%0b cnt=%0d sum=%0h want 1/1/5a", dn_wr, byte_count, checksum); end
    n_cmp++; if ((loaded !== 1'b0) || (core_reset !== 1'b1)) begin n_bad++; $display("FAIL rise_vs_ext_flags: got ld=%0b rst=%0b want 0/1", loaded, core_reset); end
    ext_reset = 1'b0;
  endtask

  task automatic test_reset_mid_download();
    int seen;
    reset_n = 1'b0;
    tick();
    tick();
    n_cmp++; if ((byte_count !== 18'd0) || (checksum !== 8'd0) || (dn_addr !== 17'd0) || (dn_data !== 8'd0) || (core_reset !== 1'b1)) begin
      n_bad++; $display("FAIL mid_reset_values: got cnt=%0d sum=%0h addr=%0h data=%0h rst=%0b", byte_count, checksum, dn_addr, dn_data, core_reset);
    end
    reset_n = 1'b1;
    tick();
    do_writes(10, 5, 1'b1, seen);
    n_cmp++; if ((seen != 0) || (byte_count !== 18'd0)) begin n_bad++; $display("FAIL mid_writes_dropped: got %0d strobes cnt=%0d want 0/0", seen, byte_count); end
    ioctl_download = 1'b0;
    tick();
    ioctl_download = 1'b1;
    tick();
    ioctl_wr = 1'b1; ioctl_addr = 25'd7; ioctl_dout = 8'h33;
    tick();
    ioctl_wr = 1'b0;
    n_cmp++; if ((dn_wr !== 1'b1) || (dn_data !== 8'h33) || (byte_count !== 18'd1)) begin n_bad++; $display("FAIL mid_new_rise: got wr=%0b data=%0h cnt=%0d want 1/33/1", dn_wr, dn_data, byte_count); end
    ioctl_download = 1'b0;
    tick();
  endtask

  initial begin
    reset_n        = 1'b0;
    ioctl_download = 1'b0;
    ioctl_wr       = 1'b0;
    ioctl_addr     = 25'd0;
    ioctl_dout     = 8'd0;
    ext_reset      = 1'b0;
    test_reset();
    test_full_load();
    test_ext_reset();
    test_short_load();
    test_overflow();
    test_edge_collision();
    test_reset_mid_download();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
